vec_popcnt_acc: RTL
===================

Name: vec_popcnt_acc

Overview:
- Sits directly downstream of the vector separator stage.
- Consumes its stream of per-vector sub-vector words and computes the popcount of each word in a registered adder tree.
- Accumulates the popcounts over the SUB_VEC_NO words of one vector and emits one (count, VecID, Last) result per vector into a small output FIFO.
- Feeds the similarity/compare stage.

Parameters:
- BUS_WIDTH, 128, width of one sub-vector word.
- VECTOR_WIDTH, 920, fingerprint width in bits.
- VEC_ID_WIDTH, 8, vector ID width.
- SUB_VEC_NO, ceil(VECTOR_WIDTH/BUS_WIDTH) = 8, words per vector (derived).
- CNT_WIDTH, clog2(VECTOR_WIDTH+1) = 10, result count width (derived).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- up_Vector  in  BUS_WIDTH  sub-vector word; padding bits are zero
- up_VecID  in  VEC_ID_WIDTH  ID of the vector the word belongs to
- up_Valid  in  1  up_Vector/up_VecID/up_Last valid
- up_Last  in  1  word is the last of the compare batch
- up_Ready  out  1  word accepted when up_Valid && up_Ready
- dn_Cnt  out  CNT_WIDTH  number of 1 bits in the vector
- dn_VecID  out  VEC_ID_WIDTH  ID of the counted vector
- dn_Valid  out  1  FIFO head valid
- dn_Last  out  1  result belongs to the last vector of the batch
- dn_Ready  in  1  pops the FIFO head when dn_Valid && dn_Ready

Behaviour:
- Reset values: up_Ready=0, dn_Valid=0, dn_Cnt=0, dn_VecID=0, dn_Last=0.
- Reset clears: sub-vector counter, accumulator, pipeline valids, FIFO pointers.
- Reset mid-vector discards the partial accumulation; no result is emitted for that vector.
- up_Ready is asserted from the first cycle after reset deassertion when credit allows.

Stage 1 (P1):
- On acceptance, register popcount(up_Vector) (clog2(BUS_WIDTH+1) bits), VecID, Last, and a "final" flag.
- final = (SubVecCntr == SUB_VEC_NO-1) || up_Last.

Stage 2 (ACC):
- acc <= (first word of vector) ? pc : acc + pc, computed at CNT_WIDTH.
- Counts above VECTOR_WIDTH cannot occur for well-formed input; they wrap modulo 2^CNT_WIDTH, with no saturation.
- VecID is captured from the first word of each vector.
- When the P1 entry is final, the next cycle pushes {acc+pc, captured VecID, Last} into the FIFO.

Latency and ordering:
- The result is visible on dn_* 3 cycles after the final word is accepted (P1, ACC, FIFO write), provided the FIFO was empty.
- Results leave in arrival order.

Sub-vector counter (states FIRST, MID, FINAL; FINAL when counter == SUB_VEC_NO-1):
- Increments on each accepted word.
- Wraps to 0 after a final word.
- Early up_Last (counter < SUB_VEC_NO-1) forces termination: a partial count is emitted with dn_Last=1 and the counter returns to 0.
- SUB_VEC_NO==1: every word is final.

Credit / backpressure:
- up_Ready = (fifo_count + finals_in_flight) < FIFO_DEPTH.
- finals_in_flight = number of final entries held in P1/ACC (0..2).
- The FIFO therefore never overflows, and pipeline stages never stall.
- Simultaneous push and pop: count unchanged, and the data stays correct.
- Push into an empty FIFO is not visible in the same cycle (registered head).
- Pop from empty is ignored.
- up_Valid low: pipeline bubbles, with no effect on the accumulator.
- dn_Ready low indefinitely: at most FIFO_DEPTH results are held; up_Ready falls accordingly.

Optional Feature:
- Macro: VEC_POPCNT_ID_CHECK_EN.
- When defined: an extra output err_IdMismatch (1 bit, reset 0) is present.
  - It becomes sticky high when an accepted non-first word carries an up_VecID different from the ID captured at the first word of that vector.
  - It is cleared only by rst.
  - The result is still emitted with the captured ID.
- When undefined: the port and compare logic are absent, and up_VecID is sampled only on first words.

Decomposition:
- Shared package fp_accel_pkg: BUS_WIDTH/VECTOR_WIDTH/VEC_ID_WIDTH defaults, SUB_VEC_NO and CNT_WIDTH derivation functions, and the state encodings FIRST/MID/FINAL.
- One natural sub-module: popcnt_tree (BUS_WIDTH in, registered popcount out, 1-cycle latency), reused later by the compare stage.
- The FIFO stays inline.

Test Plan:
- 8 all-ones words (last word 0xFFFFFF<<104, i.e. only the top 24 bits set), VecID=5, last word up_Last=1 -> dn_Cnt=920, dn_VecID=5, dn_Last=1, dn_Valid 3 cycles after the last word.
- Back-to-back vectors ID 0..3, each word with 3 bits set, dn_Ready=1 -> four results with Cnt=24 in ID order, with no up_Ready drop.
- dn_Ready=0, stream 6 vectors -> exactly 4 results buffered; up_Ready deasserts once credit is exhausted; release dn_Ready -> all 6 delivered in order with no loss.
- up_Last asserted on word index 2 of a vector (words of 10 ones each) -> dn_Cnt=30, dn_Last=1; the next vector starts at counter 0 and yields a correct full count.
- rst pulsed after 4 words of a vector -> no output; dn_Valid=0, up_Ready=0 in the reset cycle; the following vector counts correctly.
- With VEC_POPCNT_ID_CHECK_EN defined: word 3 of ID 7 carries ID 8 -> err_IdMismatch=1 from the next cycle and stays high; the result is emitted with ID 7.

Source files
------------

// File: rtl/fp_accel_pkg.sv
// Shared definitions for the fingerprint accelerator stages: default
// geometry, derived-width helpers and the sub-vector counter states.
package fp_accel_pkg;

  localparam int BUS_WIDTH_DEF    = 128;
  localparam int VECTOR_WIDTH_DEF = 920;
  localparam int VEC_ID_WIDTH_DEF = 8;

  // Position of the current word inside its vector
  typedef enum logic [1:0] {
    FIRST = 2'd0,
    MID   = 2'd1,
    FINAL = 2'd2
  } sub_state_e;

  // Number of bus words needed to carry one vector
  function automatic int calc_sub_vec_no(input int vec_width, input int bus_width);
    return (vec_width + bus_width - 1) / bus_width;
  endfunction

  // Width able to hold a popcount of 0..vec_width
  function automatic int calc_cnt_width(input int vec_width);
    return $clog2(vec_width + 1);
  endfunction

endpackage

// File: rtl/vec_popcnt_acc_popcnt_tree.sv
// popcnt_tree: popcount of one bus word, registered (1-cycle latency).
// The register only loads when i_en is high so the value is held for the
// downstream stage between accepted words.
module popcnt_tree #(
  parameter int W     = 128,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [W-1:0]     i_vec,
  output logic [OUT_W-1:0] o_cnt
);

  logic [OUT_W-1:0] w_cnt;
  logic [OUT_W-1:0] r_cnt;

  // Sum of all bits; synthesis balances the chain into an adder tree
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < W; i++) begin
      w_cnt = w_cnt + OUT_W'(i_vec[i]);
    end
  end

  // Capture the count of each accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vec_popcnt_acc.sv
// vec_popcnt_acc: accumulates per-word popcounts over one vector and queues
// one (count, VecID, Last) result per vector in a small output FIFO.
// Optional build macro VEC_POPCNT_ID_CHECK_EN adds the sticky err_IdMismatch
// output flagging non-first words whose VecID differs from the first word.
module vec_popcnt_acc
  import fp_accel_pkg::*;
#(
  parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int VEC_ID_WIDTH = VEC_ID_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 4,
  // Derived, do not override
  parameter int SUB_VEC_NO   = calc_sub_vec_no(VECTOR_WIDTH, BUS_WIDTH),
  parameter int CNT_WIDTH    = calc_cnt_width(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic [VEC_ID_WIDTH-1:0] up_VecID,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [CNT_WIDTH-1:0]    dn_Cnt,
  output logic [VEC_ID_WIDTH-1:0] dn_VecID,
  output logic                    dn_Valid,
  output logic                    dn_Last,
  input  logic                    dn_Ready
`ifdef VEC_POPCNT_ID_CHECK_EN
  ,output logic                   err_IdMismatch
`endif
);

  localparam int PC_WIDTH = $clog2(BUS_WIDTH + 1);
  localparam int SUB_W    = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CRD_W    = PTR_W + 2;
  localparam logic [SUB_W-1:0] LAST_IDX = SUB_W'(SUB_VEC_NO - 1);

  // Input side
  logic                    r_run;
  logic [SUB_W-1:0]        r_sub_cnt;
  logic [VEC_ID_WIDTH-1:0] r_cap_id;
  sub_state_e              w_sub_state;
  logic [SUB_W-1:0]        w_sub_cnt_nxt;
  logic                    w_accept;
  logic                    w_first;
  logic                    w_final;
  logic [VEC_ID_WIDTH-1:0] w_id;
  logic [CRD_W-1:0]        w_credit_used;

  // P1 stage
  logic                    r_p1_valid;
  logic                    r_p1_final;
  logic                    r_p1_first;
  logic                    r_p1_last;
  logic [VEC_ID_WIDTH-1:0] r_p1_id;
  logic [PC_WIDTH-1:0]     w_p1_pc;

  // ACC stage
  logic [CNT_WIDTH-1:0]    r_acc;
  logic [CNT_WIDTH-1:0]    w_sum;
  logic                    r_res_valid;
  logic [CNT_WIDTH-1:0]    r_res_cnt;
  logic [VEC_ID_WIDTH-1:0] r_res_id;
  logic                    r_res_last;

  // Output FIFO
  logic [CNT_WIDTH-1:0]    r_fifo_cnt  [FIFO_DEPTH];
  logic [VEC_ID_WIDTH-1:0] r_fifo_id   [FIFO_DEPTH];
  logic                    r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_fifo_count;
  logic                    w_push;
  logic                    w_pop;

  // Every final entry in P1/ACC already owns a FIFO slot, so the FIFO can
  // never overflow and the pipeline never needs to stall.
  assign w_credit_used = CRD_W'(r_fifo_count) + CRD_W'(r_p1_valid & r_p1_final)
                       + CRD_W'(r_res_valid);
  assign up_Ready = r_run & (w_credit_used < CRD_W'(FIFO_DEPTH));
  assign w_accept = up_Valid & up_Ready;
  assign w_id     = w_first ? up_VecID : r_cap_id;

  // Sub-vector position decode and next counter value
  always_comb begin
    w_sub_state   = MID;
    w_first       = (r_sub_cnt == '0);
    w_final       = up_Last;
    w_sub_cnt_nxt = r_sub_cnt;
    if (r_sub_cnt == LAST_IDX) begin
      w_sub_state = FINAL;
    end else if (r_sub_cnt == '0) begin
      w_sub_state = FIRST;
    end else begin
      w_sub_state = MID;
    end
    case (w_sub_state)
      FINAL:      w_final = 1'b1;
      FIRST, MID: w_final = up_Last;
      default:    w_final = up_Last;
    endcase
    if (w_accept) begin
      if (w_final) begin
        w_sub_cnt_nxt = '0;
      end else begin
        w_sub_cnt_nxt = r_sub_cnt + SUB_W'(1);
      end
    end else begin
      w_sub_cnt_nxt = r_sub_cnt;
    end
  end

  popcnt_tree #(
    .W     (BUS_WIDTH),
    .OUT_W (PC_WIDTH)
  ) u_popcnt_tree (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_accept),
    .i_vec (up_Vector),
    .o_cnt (w_p1_pc)
  );

  // Input counter, ID capture and P1 side-band registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run      <= 1'b0;
      r_sub_cnt  <= '0;
      r_cap_id   <= '0;
      r_p1_valid <= 1'b0;
      r_p1_final <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_id    <= '0;
    end else begin
      r_run      <= 1'b1;
      r_sub_cnt  <= w_sub_cnt_nxt;
      r_p1_valid <= w_accept;
      if (w_accept) begin
        r_p1_final <= w_final;
        r_p1_first <= w_first;
        r_p1_last  <= up_Last;
        r_p1_id    <= w_id;
        if (w_first) begin
          r_cap_id <= up_VecID;
        end
      end
    end
  end

  // First word restarts the sum; wraps modulo 2^CNT_WIDTH by construction
  assign w_sum = (r_p1_first ? '0 : r_acc) + CNT_WIDTH'(w_p1_pc);

  // Accumulator and per-vector result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_res_cnt   <= '0;
      r_res_id    <= '0;
      r_res_last  <= 1'b0;
    end else begin
      r_res_valid <= r_p1_valid & r_p1_final;
      if (r_p1_valid) begin
        r_acc <= w_sum;
        if (r_p1_final) begin
          r_res_cnt  <= w_sum;
          r_res_id   <= r_p1_id;
          r_res_last <= r_p1_last;
        end
      end
    end
  end

  assign w_push = r_res_valid;
  assign w_pop  = dn_Valid & dn_Ready;

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_cnt[i]  <= '0;
        r_fifo_id[i]   <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_cnt[r_wr_ptr]  <= r_res_cnt;
        r_fifo_id[r_wr_ptr]   <= r_res_id;
        r_fifo_last[r_wr_ptr] <= r_res_last;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + (PTR_W+1)'(1);
        2'b01:   r_fifo_count <= r_fifo_count - (PTR_W+1)'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  assign dn_Valid = (r_fifo_count != '0);
  assign dn_Cnt   = r_fifo_cnt[r_rd_ptr];
  assign dn_VecID = r_fifo_id[r_rd_ptr];
  assign dn_Last  = r_fifo_last[r_rd_ptr];

`ifdef VEC_POPCNT_ID_CHECK_EN
  logic r_err_id;

  // Sticky flag: a later word of a vector carried a different ID
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_id <= 1'b0;
    end else if (w_accept && !w_first && (up_VecID != r_cap_id)) begin
      r_err_id <= 1'b1;
    end else begin
      r_err_id <= r_err_id;
    end
  end

  assign err_IdMismatch = r_err_id;
`endif

endmodule
